iob_eth_dma_burst: RTL and testbench
====================================

// Module: iob_eth_dma_burst
// PURPOSE
//  Parametrised successor of the Ethernet RX DMA: copies bytes [start_idx, end_idx) of a byte-wide
//  frame buffer into system memory over AXI4 INCR write bursts. Sits between the RX frame buffer's
//  synchronous read port and the core's AXI4 master write channels. Adds configurable bus width,
//  multi-beat bursts, partial-word strobes, 4 KB boundary splitting and write-response error status.
// PARAMETERS
//  AXI_ADDR_W  32  memory address width
//  AXI_DATA_W  32  memory data width; 8*2^k, 8..128; NB = AXI_DATA_W/8 bytes per beat
//  BUF_ADDR_W  11  frame buffer address width (byte index)
//  BURST_LEN   16  max beats per burst, 1..256
// PORTS
//  clk          in   1           system clock
//  rst          in   1           synchronous active-high reset
//  run          in   1           start pulse; sampled only in IDLE
//  dma_addr     in   AXI_ADDR_W  memory byte address of first byte; low log2(NB) bits ignored
//  start_idx    in   BUF_ADDR_W  first buffer byte (inclusive)
//  end_idx      in   BUF_ADDR_W  last buffer byte (exclusive)
//  busy         out  1           high from accepted run until done
//  done         out  1           1-cycle pulse at end of transfer
//  err          out  1           sticky: some bresp != OKAY; cleared by next accepted run
//  buf_addr     out  BUF_ADDR_W  frame buffer read address
//  buf_data     in   8           frame buffer read data, valid 1 cycle after buf_addr
//  m_axi_awaddr out  AXI_ADDR_W  burst start address (NB-aligned)
//  m_axi_awlen  out  8           beats-1
//  m_axi_awsize out  3           log2(NB), constant
//  m_axi_awburst out 2           2'b01 INCR, constant
//  m_axi_awvalid/awready  out/in 1  address handshake
//  m_axi_wdata  out  AXI_DATA_W  beat data, byte k on lane k (little-endian)
//  m_axi_wstrb  out  NB          byte strobes
//  m_axi_wlast  out  1           last beat of burst
//  m_axi_wvalid/wready    out/in 1  data handshake
//  m_axi_bresp  in   2           write response
//  m_axi_bvalid/bready    in/out 1  response handshake
// BEHAVIOUR
//  Reset: IDLE; busy, done, err, awvalid, wvalid, bready, wlast = 0; buf_addr = 0; wdata/wstrb = 0.
//  run in IDLE: latch base = dma_addr & ~(NB-1), idx = start_idx, len = end_idx - start_idx, clear err.
//   If end_idx <= start_idx: no AXI traffic, done pulses the cycle after run, busy high that one cycle.
//   Otherwise busy = 1, go to ADDR. run while busy is ignored.
//  Words W = ceil(len/NB). Per burst: beats = min(words left, BURST_LEN, (4096 - addr[11:0])/NB);
//   a burst never crosses a 4 KB boundary.
//  States: IDLE -> ADDR -> FILL -> BEAT -> (FILL | RESP) -> (ADDR | FIN) -> IDLE.
//   ADDR: awvalid=1 with awaddr/awlen held stable until awready; then FILL.
//   FILL: issue NB consecutive buf_addr reads (idx++); pack returned bytes into lanes 0..NB-1;
//    bytes at or past end_idx: data 0, strobe 0 (no buffer read). NB+1 cycles per beat.
//   BEAT: wvalid=1, wdata/wstrb/wlast stable until wready; wlast on beat awlen. Next FILL or RESP.
//   RESP: bready=1; on bvalid: bresp != 2'b00 sets err. If err or no words left -> FIN,
//    else addr += beats*NB -> ADDR. An error aborts remaining bursts.
//   FIN: done=1 for one cycle, busy drops the same cycle; -> IDLE.
//  awvalid is never raised before the previous burst's bresp is taken (one outstanding burst).
//  Index arithmetic is BUF_ADDR_W-bit modulo; address arithmetic is AXI_ADDR_W-bit.
//  wstrb all-ones except on the final beat of the transfer when len % NB != 0.
//  rst mid-transfer: immediate return to IDLE, all valids drop (system reset only; AXI slave reset too).
// TESTING
//  AXI_DATA_W=32, addr=0x1000, start=0, end=46, awready/wready/bvalid always 1 -> one burst awlen=11,
//   12 beats, final wstrb=4'b0011, done once, err=0, memory matches buffer.
//  start=10, end=10 -> done 1 cycle after run, no awvalid, busy high 1 cycle.
//  addr=0x0FF0, 64 bytes, BURST_LEN=16 -> bursts at 0x0FF0 awlen=3 then 0x1000 awlen=11.
//  Random awready/wready/bvalid stalls (0-5 cycles) -> payload stable under stall, data identical.
//  bresp=2'b10 on first of 3 bursts -> err=1, no further awvalid, done pulses; next run clears err.
//  rst asserted mid-BEAT -> next cycle awvalid=wvalid=busy=0; new run completes normally.

Source files
------------

// File: rtl/iob_eth_dma_burst.sv
// Copies buffer bytes [start_idx, end_idx) to memory as AXI4 INCR write bursts, one burst outstanding.
// Latency: NB+1 cycles per beat to fill from the byte buffer, plus the address and response handshakes.
// Backpressure: awvalid/wvalid hold address and data stable until ready; the next burst waits for bresp.
module iob_eth_dma_burst #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int BUF_ADDR_W = 11,
  parameter int BURST_LEN  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic [AXI_ADDR_W-1:0]   dma_addr,
  input  logic [BUF_ADDR_W-1:0]   start_idx,
  input  logic [BUF_ADDR_W-1:0]   end_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [BUF_ADDR_W-1:0]   buf_addr,
  input  logic [7:0]              buf_data,
  output logic [AXI_ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [AXI_DATA_W-1:0]   m_axi_wdata,
  output logic [AXI_DATA_W/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam int NB  = AXI_DATA_W / 8;
  localparam int LNB = $clog2(NB);
  localparam int LIW = (NB > 1) ? LNB : 1;   // lane index width
  localparam int LCW = $clog2(NB + 1);       // lane counter runs 0..NB
  localparam int WLW = BUF_ADDR_W + 1;       // word counter width

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_FILL, S_BEAT, S_RESP, S_FIN} state_t;
  state_t state, state_nx;

  logic [AXI_ADDR_W-1:0] addr_q;
  logic [BUF_ADDR_W-1:0] idx_q, bytes_left;
  logic [WLW-1:0]        words_left;
  logic [8:0]            burst_beats, beat_cnt, beats_c;
  logic [LCW-1:0]        lane_cnt;
  logic [LIW-1:0]        lane_idx, rd_lane;
  logic                  rd_pend, err_q;
  logic [AXI_DATA_W-1:0] wdata_q;
  logic [NB-1:0]         wstrb_q;
  logic [BUF_ADDR_W-1:0] len_in;
  logic [WLW-1:0]        words_in;
  logic [12:0]           room4k;
  logic                  fill_done, last_beat;

  assign len_in    = end_idx - start_idx;
  assign words_in  = ({1'b0, len_in} + WLW'(NB - 1)) >> LNB;
  assign room4k    = (13'd4096 - {1'b0, addr_q[11:0]}) >> LNB;
  assign lane_idx  = LIW'(lane_cnt);
  assign fill_done = (lane_cnt == LCW'(NB));
  assign last_beat = (beat_cnt == burst_beats - 9'd1);

  // Burst size: words left, capped by the burst limit and by the distance to the next 4 KB page
  always_comb begin
    if (32'(words_left) <= 32'(BURST_LEN) && 32'(words_left) <= 32'(room4k))
      beats_c = 9'(words_left);
    else if (32'(BURST_LEN) <= 32'(room4k))
      beats_c = 9'(BURST_LEN);
    else
      beats_c = 9'(room4k);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and state-decoded handshake outputs
  always_comb begin
    state_nx      = state;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    done          = 1'b0;
    busy          = (state != S_IDLE);
    case (state)
      S_IDLE: if (run) state_nx = (end_idx <= start_idx) ? S_FIN : S_ADDR;
      S_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nx = S_FILL;
      end
      S_FILL: if (fill_done) state_nx = S_BEAT;
      S_BEAT: begin
        m_axi_wvalid = 1'b1;
        if (m_axi_wready) state_nx = last_beat ? S_RESP : S_FILL;
      end
      S_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (err_q || m_axi_bresp != 2'b00 || words_left == WLW'(0)) state_nx = S_FIN;
          else                                                          state_nx = S_ADDR;
        end
      end
      S_FIN: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: run capture, burst setup, byte-to-lane packing, beat accounting, error capture
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      idx_q       <= '0;
      bytes_left  <= '0;
      words_left  <= '0;
      burst_beats <= '0;
      beat_cnt    <= '0;
      lane_cnt    <= '0;
      rd_lane     <= '0;
      rd_pend     <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      case (state)
        S_IDLE: if (run) begin
          addr_q     <= dma_addr & ~AXI_ADDR_W'(NB - 1);
          idx_q      <= start_idx;
          bytes_left <= len_in;
          words_left <= words_in;
          err_q      <= 1'b0;
        end
        S_ADDR: if (m_axi_awready) begin
          burst_beats <= beats_c;
          beat_cnt    <= '0;
          lane_cnt    <= '0;
          rd_pend     <= 1'b0;
        end
        S_FILL: begin
          // The byte requested last cycle arrives now
          if (rd_pend) wdata_q[8*rd_lane +: 8] <= buf_data;
          if (!fill_done) begin
            if (bytes_left != '0) begin
              wstrb_q[lane_idx] <= 1'b1;
              rd_pend           <= 1'b1;
              rd_lane           <= lane_idx;
              idx_q             <= idx_q + 1'b1;
              bytes_left        <= bytes_left - 1'b1;
            end else begin
              // Past the end of the frame: empty lane, no buffer read
              wstrb_q[lane_idx]         <= 1'b0;
              wdata_q[8*lane_idx +: 8]  <= 8'h00;
              rd_pend                   <= 1'b0;
            end
            lane_cnt <= lane_cnt + 1'b1;
          end else begin
            rd_pend <= 1'b0;
          end
        end
        S_BEAT: if (m_axi_wready) begin
          beat_cnt   <= beat_cnt + 9'd1;
          words_left <= words_left - 1'b1;
          addr_q     <= addr_q + AXI_ADDR_W'(NB);
          lane_cnt   <= '0;
        end
        S_RESP: if (m_axi_bvalid && m_axi_bresp != 2'b00) err_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign err           = err_q;
  assign buf_addr      = idx_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'(beats_c - 9'd1);
  assign m_axi_awsize  = 3'(LNB);
  assign m_axi_awburst = 2'b01;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wlast   = (state == S_BEAT) && last_beat;

endmodule

// File: tb/tb_iob_eth_dma_burst.sv
// Bench for iob_eth_dma_burst: byte buffer model, AXI write slave with optional stalls, scoreboards.
// Stimulus pushes expected AW/W traffic; an independent monitor pops and compares on each handshake.
// Covers reset values, single/multi/4K-split bursts, empty transfer, stalls, error abort, mid-beat reset.
module tb_iob_eth_dma_burst;

  logic        clk = 1'b0;
  logic        rst, run;
  logic [31:0] dma_addr;
  logic [10:0] start_idx, end_idx, buf_addr;
  logic        busy, done, err;
  logic [7:0]  buf_data;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  iob_eth_dma_burst dut (
    .clk(clk), .rst(rst), .run(run), .dma_addr(dma_addr), .start_idx(start_idx), .end_idx(end_idx),
    .busy(busy), .done(done), .err(err), .buf_addr(buf_addr), .buf_data(buf_data),
    .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  typedef struct packed {logic [31:0] addr; logic [7:0] len;} aw_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} w_t;

  logic [7:0] bufm [0:2047];
  logic [7:0] sysmem [int];
  aw_t        aw_q[$];
  w_t         w_q[$];
  logic [1:0] resp_q[$];

  int  n_chk = 0, n_fail = 0, done_cnt = 0, resp_pend = 0;
  logic stall_mode = 1'b0, hold_w = 1'b0;

  // Synchronous-read frame buffer
  always @(posedge clk) buf_data <= bufm[buf_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // AXI slave + monitor: drive readies at negedge, evaluate the coming handshake 1 time unit later
  initial begin : monitor
    logic aw_stall, w_stall, b_done;
    aw_t  aw_sav;
    w_t   w_sav;
    aw_t  aw_exp;
    w_t   w_exp;
    int   cur_waddr;
    aw_stall = 1'b0; w_stall = 1'b0; b_done = 1'b0; cur_waddr = 0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
    forever begin
      @(negedge clk);
      awready = stall_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
      wready  = hold_w ? 1'b0 : stall_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (!(bvalid && !b_done)) begin
        bvalid = 1'b0;
        if (resp_pend > 0 && (!stall_mode || $urandom_range(0, 2) == 0)) begin
          bvalid = 1'b1;
          bresp  = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
        end
      end
      b_done = 1'b0;
      #1;
      if (rst) begin
        aw_stall = 1'b0; w_stall = 1'b0; resp_pend = 0; bvalid = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (aw_stall) chk("aw_stable", {awvalid, awaddr, awlen}, {1'b1, aw_sav});
        aw_stall = 1'b0;
        if (awvalid) begin
          if (awready) begin
            if (aw_q.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL aw_unexpected: got awaddr %0h awlen %0d expected no burst", awaddr, awlen);
            end else begin
              aw_exp = aw_q.pop_front();
              chk("aw_addr_len", {awaddr, awlen}, aw_exp);
              chk("aw_size_burst", {awsize, awburst}, {3'd2, 2'b01});
            end
            cur_waddr = int'(awaddr);
          end else begin
            aw_stall = 1'b1;
            aw_sav   = {awaddr, awlen};
          end
        end
        if (w_stall) chk("w_stable", {wvalid, wdata, wstrb, wlast}, {1'b1, w_sav});
        w_stall = 1'b0;
        if (wvalid) begin
          if (wready) begin
            if (w_q.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL w_unexpected: got wdata %0h expected no beat", wdata);
            end else begin
              w_exp = w_q.pop_front();
              chk("w_beat", {wdata, wstrb, wlast}, w_exp);
            end
            for (int k = 0; k < 4; k++) if (wstrb[k]) sysmem[cur_waddr + k] = wdata[8*k +: 8];
            cur_waddr += 4;
            if (wlast) resp_pend++;
          end else begin
            w_stall = 1'b1;
            w_sav   = {wdata, wstrb, wlast};
          end
        end
        if (bvalid && bready) begin
          resp_pend--;
          b_done = 1'b1;
        end
      end
    end
  end

  task automatic expect_data(input int s, input int e, input int b0, input int b1, input int b2);
    int bl[3];
    int idx;
    w_t w;
    bl  = '{b0, b1, b2};
    idx = s;
    for (int b = 0; b < 3; b++) begin
      for (int n = 0; n < bl[b]; n++) begin
        w = '0;
        for (int k = 0; k < 4; k++) begin
          if (idx + k < e) begin
            w.data[8*k +: 8] = bufm[idx + k];
            w.strb[k]        = 1'b1;
          end
        end
        w.last = (n == bl[b] - 1);
        w_q.push_back(w);
        idx += 4;
      end
    end
  endtask

  task automatic start_run(input logic [31:0] a, input int s, input int e, output int base);
    @(negedge clk);
    base      = done_cnt;
    dma_addr  = a;
    start_idx = 11'(s);
    end_idx   = 11'(e);
    run       = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_done(input string name, input int base, input int budget);
    int cyc;
    cyc = 0;
    while (done_cnt == base && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_done_seen"}, 64'(done_cnt != base), 64'd1);
    repeat (3) @(negedge clk);
    #2;
    chk({name, "_done_once"}, 64'(done_cnt - base), 64'd1);
    chk({name, "_idle"}, {busy, awvalid, wvalid}, 3'b000);
    chk({name, "_queues_drained"}, 64'(aw_q.size() + w_q.size()), 64'd0);
  endtask

  task automatic mem_check(input string name, input int a, input int s, input int e);
    int bad;
    bad = 0;
    for (int i = s; i < e; i++)
      if (!sysmem.exists(a + i - s) || sysmem[a + i - s] !== bufm[i]) bad++;
    chk({name, "_mem"}, 64'(bad), 64'd0);
  endtask

  initial begin : stim
    int base;
    int cyc;
    for (int i = 0; i < 2048; i++) bufm[i] = 8'((i * 13 + 5) ^ (i >> 4));
    rst = 1'b1; run = 1'b0; dma_addr = '0; start_idx = '0; end_idx = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_status", {busy, done, err}, 3'b000);
    chk("rst_valids", {awvalid, wvalid, bready, wlast}, 4'b0000);
    chk("rst_buf_addr", 64'(buf_addr), 64'd0);
    chk("rst_wdata_wstrb", {wdata, wstrb}, 36'd0);
    rst = 1'b0;

    // Single burst of 12 beats, partial last word
    aw_q.push_back({32'h1000, 8'd11});
    expect_data(0, 46, 12, 0, 0);
    start_run(32'h1000, 0, 46, base);
    wait_done("t1", base, 1000);
    chk("t1_err", 64'(err), 64'd0);
    mem_check("t1", 32'h1000, 0, 46);
    chk("t1_tail_unwritten", 64'(sysmem.exists(32'h1000 + 46)), 64'd0);

    // Empty transfer: done and busy for exactly one cycle, no address phase
    start_run(32'h7000, 10, 10, base);
    #2;
    chk("t2_first_cycle", {done, busy, awvalid}, 3'b110);
    @(negedge clk);
    #2;
    chk("t2_second_cycle", {done, busy, awvalid}, 3'b000);

    // 4 KB page split
    aw_q.push_back({32'h0FF0, 8'd3});
    aw_q.push_back({32'h1000, 8'd11});
    expect_data(100, 164, 4, 12, 0);
    start_run(32'h0FF0, 100, 164, base);
    wait_done("t3", base, 1000);
    mem_check("t3", 32'h0FF0, 100, 164);

    // Random stalls on all three channels
    stall_mode = 1'b1;
    aw_q.push_back({32'h2004, 8'd15});
    aw_q.push_back({32'h2044, 8'd1});
    expect_data(5, 75, 16, 2, 0);
    start_run(32'h2007, 5, 75, base);
    wait_done("t4", base, 3000);
    mem_check("t4", 32'h2004, 5, 75);
    stall_mode = 1'b0;

    // Error response on the first of three bursts aborts the rest
    resp_q.push_back(2'b10);
    aw_q.push_back({32'h4000, 8'd15});
    expect_data(200, 330, 16, 0, 0);
    start_run(32'h4000, 200, 330, base);
    wait_done("t5", base, 1000);
    chk("t5_err_set", 64'(err), 64'd1);
    aw_q.push_back({32'h5000, 8'd0});
    expect_data(0, 4, 1, 0, 0);
    start_run(32'h5000, 0, 4, base);
    #2;
    chk("t5_err_cleared", 64'(err), 64'd0);
    wait_done("t5b", base, 500);
    chk("t5b_err", 64'(err), 64'd0);
    mem_check("t5b", 32'h5000, 0, 4);

    // Reset while a beat is stalled, then a clean transfer
    hold_w = 1'b1;
    aw_q.push_back({32'h6000, 8'd1});
    start_run(32'h6000, 0, 8, base);
    cyc = 0;
    while (!wvalid && cyc < 100) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    chk("t6_reached_beat", 64'(wvalid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    w_q.delete();
    aw_q.delete();
    @(negedge clk);
    rst    = 1'b0;
    hold_w = 1'b0;
    #2;
    chk("t6_after_rst", {awvalid, wvalid, busy, bready}, 4'b0000);
    aw_q.push_back({32'h6100, 8'd2});
    expect_data(20, 30, 3, 0, 0);
    start_run(32'h6100, 20, 30, base);
    wait_done("t6", base, 500);
    chk("t6_err", 64'(err), 64'd0);
    mem_check("t6", 32'h6100, 20, 30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
